m_stage_mem_unit: RTL and testbench
===================================

# m_stage_mem_unit

Memory-stage data access unit of the five-stage MIPS pipeline, between the E_M pipeline register and the M_W register. It decodes the M-stage memory operation, generates byte-aligned bus requests with a wait-state handshake, extends load data, detects address exceptions and maintains the LL/SC reservation. It supplies `readData_M` and `llBit_M` to M_W and `stall_M` to the hazard unit.

## Interface
- No parameters.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `mem_op_M` in 4: decoded memory operation (package enum; NONE when not a memory instruction).
- `addr_M` in 32: effective address.
- `wdata_M` in 32: forwarded rt value.
- `Req` in 1: exception/interrupt flush of the M stage.
- `bus_req` out 1: access request.
- `bus_addr` out 32: `{addr_M[31:2],2'b00}`.
- `bus_wdata` out 32: store data, lane-replicated.
- `bus_byteen` out 4: write lane enables; 0000 for loads.
- `bus_ack` in 1: access complete, may arrive in the same cycle as `bus_req`.
- `bus_rdata` in 32: read word, valid with `bus_ack`.
- `readData_M` out 32: extended load result.
- `llBit_M` out 1: SC result written to rt.
- `exc_code_M` out 5: 4 = AdEL, 5 = AdES, 0 = none.
- `stall_M` out 1: freeze F..M and bubble W.

## Operation
- Alignment: LW/LL/SW/SC require `addr[1:0]==0`; LH/LHU/SH require `addr[0]==0`. A misaligned access sets `exc_code_M` combinationally, holds `bus_req` at 0 and holds `stall_M` at 0.
- Stores: SW uses byteen 1111. SH uses 0011 or 1100 by `addr[1]`, with wdata `{2{h}}`. SB uses `1<<addr[1:0]`, with wdata `{4{b}}`. Little-endian.
- Loads: select the byte or halfword by `addr[1:0]`. LB and LH sign-extend; LBU and LHU zero-extend.
- State machine:
  - IDLE: a valid aligned op with no `Req` drives `bus_req=1`.
    - Same-cycle `bus_ack`: the access completes with zero wait. `readData_M` comes from `bus_rdata` and the state stays IDLE.
    - No ack: `stall_M=1` and the state goes to WAIT.
  - WAIT: `bus_req=1`, `stall_M=1`. On `bus_ack`, latch `bus_rdata` into the hold register and go to DONE.
  - DONE: `bus_req=0`, `stall_M=0`. `readData_M` comes from the hold register. Return to IDLE next cycle and do not reissue.
- `Req` in any state drops `bus_req` and forces the next state to IDLE. The bus tolerates an abandoned request.
- The E_M register holds `mem_op_M`, `addr_M` and `wdata_M` stable while `stall_M=1`.
- LL/SC:
  - LL completing sets `llbit=1` and `resv_addr=addr[31:2]`.
  - SC succeeds only if `llbit` is set and `resv_addr` matches. On success it issues a 1111 store and `llBit_M=1`.
  - On failure SC issues no bus request, does not stall, and `llBit_M=0`.
  - Every SC clears `llbit` in its completion cycle.
  - `Req` clears `llbit`. A simultaneous `Req` and completion gives clear priority.
- Reset values: state IDLE, hold register 0, `llbit` 0, `resv_addr` 0. All outputs are 0.

## Timing
- Zero-wait access: result in the issue cycle, no stall.
- Ack k cycles after issue (k≥1): `stall_M` is high for k+1 cycles and the result is valid in the following DONE cycle.
- `readData_M`, `llBit_M` and `exc_code_M` are valid only in cycles where `stall_M=0`.
- Reset mid-WAIT: IDLE next cycle, with `bus_req` low in that cycle.

## Configuration
- `LLSC_EN` defined: LL/SC behave as above.
- Not defined:
  - The reservation logic is absent and `llBit_M` is tied to 0.
  - LL and SC decode as NONE: no bus request, no exception from this block. The decoder raises RI.

## Structure
- The shared package `cpu_mem_pkg` holds:
  - the `mem_op_t` enum (NONE, LW, LH, LHU, LB, LBU, SW, SH, SB, LL, SC);
  - the exception codes `EXC_ADEL` and `EXC_ADES`;
  - the FSM state enum.
- Sub-module `llsc_resv` holds the reservation register, address compare and clear priority. It is instantiated only under `LLSC_EN`.

## Test plan
- LB at 0x1003, rdata 0x80FF_1234, zero-wait → `readData_M` = 0xFFFF_FF80, no stall.
- SH at 0x2002, wdata 0x0000_BEEF → byteen 1100, `bus_wdata` 0xBEEF_BEEF, `bus_addr` 0x2000.
- LW at 0x3000, ack 3 cycles after issue, rdata 0xDEAD_BEEF → `stall_M` high 4 cycles, then `readData_M` = 0xDEAD_BEEF for one cycle with no reissue.
- LW at 0x3001 → `exc_code_M` = 4 and `bus_req` = 0. SW at 0x3002 → `exc_code_M` = 5.
- LL 0x4000 then SC 0x4000 → store issued and `llBit_M` = 1. A second SC 0x4000 → no store and `llBit_M` = 0.
- LL 0x4000, then `Req`, then SC 0x4000 → SC fails. `Req` during WAIT → `bus_req` low next cycle and state IDLE.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared M-stage memory-access types: operation enum, exception codes, FSM states
// and a decoder from operation to access attributes.
package cpu_mem_pkg;

    typedef enum logic [3:0] {
        NONE = 4'd0, LW, LH, LHU, LB, LBU, SW, SH, SB, LL, SC
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic       sext;
        logic [1:0] size;
    } mem_dec_t;

    function automatic mem_dec_t decode_mem_op(input mem_op_t op);
        mem_dec_t d;
        d = '0;
        case (op)
            LW, LL:  begin d.is_load  = 1'b1; d.size = SZ_WORD; end
            LH:      begin d.is_load  = 1'b1; d.size = SZ_HALF; d.sext = 1'b1; end
            LHU:     begin d.is_load  = 1'b1; d.size = SZ_HALF; end
            LB:      begin d.is_load  = 1'b1; d.size = SZ_BYTE; d.sext = 1'b1; end
            LBU:     begin d.is_load  = 1'b1; d.size = SZ_BYTE; end
            SW, SC:  begin d.is_store = 1'b1; d.size = SZ_WORD; end
            SH:      begin d.is_store = 1'b1; d.size = SZ_HALF; end
            SB:      begin d.is_store = 1'b1; d.size = SZ_BYTE; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/m_stage_mem_unit_llsc_resv.sv
// LL/SC reservation: link bit plus reserved word address. A flush or reset
// always wins over a same-cycle LL/SC completion.
module llsc_resv (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        set_en,
    input  logic        clr_en,
    input  logic [29:0] addr_word,
    output logic        match
);

    logic        llbit_reg;
    logic [29:0] resv_addr_reg;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            llbit_reg <= 1'b0;
        end else if (clr_en) begin
            llbit_reg <= 1'b0;
        end else if (set_en) begin
            llbit_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resv_addr_reg <= '0;
        end else if (set_en && !flush && !clr_en) begin
            resv_addr_reg <= addr_word;
        end
    end

    assign match = llbit_reg && (resv_addr_reg == addr_word);

endmodule

// File: rtl/m_stage_mem_unit.sv
// M-stage data access: bus request/wait handshake, lane steering, load extension,
// address exceptions. LL/SC reservation is built only when LLSC_EN is defined.
module m_stage_mem_unit
    import cpu_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  mem_op_t     mem_op_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    input  logic        Req,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] readData_M,
    output logic        llBit_M,
    output logic [4:0]  exc_code_M,
    output logic        stall_M
);

    mem_op_t     op_eff;
    mem_dec_t    dec;
    mem_state_t  state_reg, state_next;
    logic [31:0] hold_reg;
    logic        misaligned, sc_block, sc_drop, issue, sc_ok;
    logic        fsm_req, fsm_stall, complete, use_hold;
    logic [31:0] src_word, ext_word, lane_data;
    logic [3:0]  lane_en;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        op_eff = mem_op_M;
`ifndef LLSC_EN
        if (mem_op_M == LL || mem_op_M == SC) op_eff = NONE;
`endif
    end

    assign dec = decode_mem_op(op_eff);

    always_comb begin
        case (dec.size)
            SZ_WORD: misaligned = (addr_M[1:0] != 2'b00);
            SZ_HALF: misaligned = addr_M[0];
            default: misaligned = 1'b0;
        endcase
    end

`ifdef LLSC_EN
    logic is_ll, is_sc, resv_match;

    assign is_ll    = (op_eff == LL);
    assign is_sc    = (op_eff == SC);
    assign sc_block = is_sc && !resv_match;
    assign sc_ok    = complete && is_sc && resv_match;

    llsc_resv u_llsc_resv (
        .clk       (clk),
        .reset     (reset),
        .flush     (Req),
        .set_en    (complete && is_ll),
        .clr_en    (complete && is_sc),
        .addr_word (addr_M[31:2]),
        .match     (resv_match)
    );
`else
    assign sc_block = 1'b0;
    assign sc_ok    = 1'b0;
`endif

    assign issue   = (dec.is_load || dec.is_store) && !misaligned && !sc_block && !Req;
    // A failing SC completes in place: no bus access, but it still retires the link bit.
    assign sc_drop = sc_block && !misaligned && !Req;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (issue && !bus_ack) state_next = ST_WAIT;
            ST_WAIT: begin
                if (Req)          state_next = ST_IDLE;
                else if (bus_ack) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fsm_req   = 1'b0;
        fsm_stall = 1'b0;
        complete  = 1'b0;
        use_hold  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                fsm_req   = issue;
                fsm_stall = issue && !bus_ack;
                complete  = issue ? bus_ack : sc_drop;
            end
            ST_WAIT: begin
                fsm_req   = !Req;
                fsm_stall = !Req;
            end
            ST_DONE: begin
                complete  = !Req;
                use_hold  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg <= '0;
        end else if (state_reg == ST_WAIT && bus_ack && !Req) begin
            hold_reg <= bus_rdata;
        end
    end

    assign src_word = use_hold ? hold_reg : bus_rdata;
    assign half_sel = addr_M[1] ? src_word[31:16] : src_word[15:0];
    assign byte_sel = src_word[{addr_M[1:0], 3'b000} +: 8];

    always_comb begin
        case (dec.size)
            SZ_WORD: ext_word = src_word;
            SZ_HALF: ext_word = {{16{dec.sext & half_sel[15]}}, half_sel};
            default: ext_word = {{24{dec.sext & byte_sel[7]}}, byte_sel};
        endcase
    end

    // Little-endian lane steering: narrow stores replicate their data across all lanes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_en[gi] = (dec.size == SZ_WORD) ||
                             ((dec.size == SZ_HALF) && (addr_M[1] == 1'(gi / 2))) ||
                             ((dec.size == SZ_BYTE) && (addr_M[1:0] == 2'(gi)));
        assign lane_data[gi*8 +: 8] = (dec.size == SZ_WORD) ? wdata_M[gi*8 +: 8] :
                                      (dec.size == SZ_HALF) ? wdata_M[(gi%2)*8 +: 8] :
                                                              wdata_M[7:0];
    end

    assign bus_req    = !reset && fsm_req;
    assign stall_M    = !reset && fsm_stall;
    assign bus_addr   = reset ? 32'd0 : {addr_M[31:2], 2'b00};
    assign bus_byteen = (!reset && fsm_req && dec.is_store) ? lane_en : 4'b0000;
    assign bus_wdata  = (!reset && dec.is_store) ? lane_data : 32'd0;
    assign readData_M = (!reset && complete && dec.is_load) ? ext_word : 32'd0;
    assign llBit_M    = !reset && sc_ok;
    assign exc_code_M = (reset || !misaligned) ? EXC_NONE :
                        (dec.is_load ? EXC_ADEL : EXC_ADES);

endmodule

// File: tb/tb_m_stage_mem_unit.sv
// Self-checking bench for m_stage_mem_unit: directed cases plus random transactions
// checked against a byte/arithmetic reference model. Honours LLSC_EN.
module tb_m_stage_mem_unit;
    import cpu_mem_pkg::*;

`ifdef LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    logic        clk, reset, Req, bus_ack, bus_req, llBit_M, stall_M;
    mem_op_t     mem_op_M;
    logic [31:0] addr_M, wdata_M, bus_addr, bus_wdata, bus_rdata, readData_M;
    logic [3:0]  bus_byteen;
    logic [4:0]  exc_code_M;

    int pass_cnt = 0;
    int total_cnt = 0;

    bit          resv_valid = 1'b0;
    logic [29:0] resv_word  = '0;

    m_stage_mem_unit dut (
        .clk(clk), .reset(reset), .mem_op_M(mem_op_M), .addr_M(addr_M),
        .wdata_M(wdata_M), .Req(Req), .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_byteen(bus_byteen), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .readData_M(readData_M), .llBit_M(llBit_M),
        .exc_code_M(exc_code_M), .stall_M(stall_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int op_bytes(input mem_op_t op);
        case (op)
            LW, SW:      return 4;
            LH, LHU, SH: return 2;
            LB, LBU, SB: return 1;
            LL, SC:      return LLSC ? 4 : 0;
            default:     return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                               input int nb, input bit sgn);
        logic [31:0] v, mask;
        v = word >> (8 * off);
        if (nb == 4) return v;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v = v & mask;
        if (sgn && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int nb);
        if (nb == 1) return wd[7:0] * 32'h0101_0101;
        if (nb == 2) return wd[15:0] * 32'h0001_0001;
        return wd;
    endfunction

    // One M-stage instruction with the bus acking k cycles after issue.
    task automatic run_txn(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int k);
        int          nb;
        bit          ld, st, mis, sc_ok, go;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        logic [4:0]  exp_exc;
        nb     = op_bytes(op);
        ld     = (nb != 0) && (op inside {LW, LH, LHU, LB, LBU, LL});
        st     = (nb != 0) && (op inside {SW, SH, SB, SC});
        mis    = (nb != 0) && ((addr % nb) != 0);
        sc_ok  = (op == SC) && LLSC && resv_valid && (resv_word == addr[31:2]);
        go     = (ld || st) && !mis && !((op == SC) && !sc_ok);
        exp_exc = !mis ? 5'd0 : (ld ? 5'd4 : 5'd5);
        exp_be  = (go && st) ? 4'(((32'd1 << nb) - 32'd1) << addr[1:0]) : 4'b0000;
        exp_rd  = (go && ld) ? model_load(rd, addr[1:0], nb, op inside {LB, LH}) : 32'd0;

        @(negedge clk);
        mem_op_M = op; addr_M = addr; wdata_M = wd; Req = 1'b0;
        bus_ack = go && (k == 0);
        bus_rdata = (k == 0) ? rd : $urandom;
        #1;
        $display("txn %s addr=%08h wd=%08h rd=%08h k=%0d go=%0b", op.name(), addr, wd, rd, k, go);
        check("exc_code", exc_code_M, exp_exc);
        check("issue.bus_req", bus_req, go);
        check("issue.stall", stall_M, go && (k != 0));
        check("bus_byteen", bus_byteen, exp_be);
        if (go) check("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
        if (go && st) check("bus_wdata", bus_wdata, model_wdata(wd, nb));
        if (!go || k == 0) begin
            check("readData", readData_M, exp_rd);
            check("llBit", llBit_M, sc_ok);
        end else begin
            for (int i = 1; i <= k; i++) begin
                @(negedge clk);
                bus_ack = (i == k);
                bus_rdata = (i == k) ? rd : $urandom;
                #1;
                check("wait.bus_req", bus_req, 1'b1);
                check("wait.stall", stall_M, 1'b1);
            end
            @(negedge clk);
            bus_ack = 1'b0; bus_rdata = $urandom;
            #1;
            check("done.bus_req", bus_req, 1'b0);
            check("done.stall", stall_M, 1'b0);
            check("done.readData", readData_M, exp_rd);
            check("done.llBit", llBit_M, sc_ok);
        end
        if (go && op == LL) begin
            resv_valid = 1'b1;
            resv_word  = addr[31:2];
        end
        if (op == SC && !mis) resv_valid = 1'b0;
    endtask

    task automatic idle_cycle(input bit req_in);
        @(negedge clk);
        mem_op_M = NONE; Req = req_in; bus_ack = 1'b0;
        #1;
        check("idle.bus_req", bus_req, 1'b0);
        check("idle.stall", stall_M, 1'b0);
        if (req_in) resv_valid = 1'b0;
        Req = 1'b0;
    endtask

    initial begin
        logic [3:0]  r;
        mem_op_t     op;
        logic [31:0] a;

        reset = 1'b1; Req = 1'b0; mem_op_M = SW; addr_M = 32'h1000;
        wdata_M = 32'h1234_5678; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        #1;
        $display("reset state");
        check("rst.bus_req", bus_req, 1'b0);
        check("rst.stall", stall_M, 1'b0);
        check("rst.byteen", bus_byteen, 4'b0000);
        check("rst.wdata", bus_wdata, 32'd0);
        check("rst.addr", bus_addr, 32'd0);
        check("rst.readData", readData_M, 32'd0);
        check("rst.llBit", llBit_M, 1'b0);
        check("rst.exc", exc_code_M, 5'd0);
        @(negedge clk);
        reset = 1'b0; mem_op_M = NONE; bus_ack = 1'b0;

        run_txn(LB, 32'h1003, 32'd0, 32'h80FF_1234, 0);
        run_txn(SH, 32'h2002, 32'h0000_BEEF, 32'd0, 0);
        run_txn(LW, 32'h3000, 32'd0, 32'hDEAD_BEEF, 3);
        idle_cycle(1'b0);
        run_txn(LW, 32'h3001, 32'd0, 32'd0, 0);
        run_txn(SW, 32'h3002, 32'h1111_2222, 32'd0, 0);
        run_txn(LHU, 32'h3006, 32'd0, 32'h8001_7FFF, 2);
        run_txn(LH, 32'h3006, 32'd0, 32'h8001_7FFF, 0);
        run_txn(SB, 32'h3007, 32'h0000_00A5, 32'd0, 1);

        run_txn(LL, 32'h4000, 32'd0, 32'h0000_0042, 1);
        run_txn(SC, 32'h4000, 32'h5555_AAAA, 32'd0, 0);
        run_txn(SC, 32'h4000, 32'h5555_AAAA, 32'd0, 0);
        run_txn(LL, 32'h4000, 32'd0, 32'h0000_0042, 0);
        idle_cycle(1'b1);
        run_txn(SC, 32'h4000, 32'h5555_AAAA, 32'd0, 0);

        // Flush while waiting: request dropped at once, FSM back in IDLE.
        @(negedge clk);
        mem_op_M = LW; addr_M = 32'h5000; Req = 1'b0; bus_ack = 1'b0;
        #1;
        $display("flush during WAIT");
        check("flush.issue_stall", stall_M, 1'b1);
        @(negedge clk);
        Req = 1'b1;
        #1;
        check("flush.bus_req", bus_req, 1'b0);
        check("flush.stall", stall_M, 1'b0);
        resv_valid = 1'b0;
        idle_cycle(1'b0);
        run_txn(LW, 32'h5004, 32'd0, 32'h0BAD_F00D, 0);

        // Reset while waiting.
        @(negedge clk);
        mem_op_M = LW; addr_M = 32'h6000; bus_ack = 1'b0;
        #1;
        $display("reset during WAIT");
        check("rstwait.issue_stall", stall_M, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstwait.bus_req", bus_req, 1'b0);
        @(negedge clk);
        reset = 1'b0; mem_op_M = NONE;
        #1;
        check("rstwait.after_bus_req", bus_req, 1'b0);
        check("rstwait.after_stall", stall_M, 1'b0);
        resv_valid = 1'b0;
        run_txn(LW, 32'h6004, 32'd0, 32'h1357_9BDF, 0);

        for (int n = 0; n < 80; n++) begin
            r  = 4'($urandom_range(0, 10));
            op = mem_op_t'(r);
            a  = $urandom;
            if (op == LL || op == SC) a = 32'h4000 + {29'd0, 1'($urandom_range(0, 1)), 2'b00};
            else if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_txn(op, a, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
